// File: rtl/lector_fifo_pkg.sv
// Shared constants for the FIFO consumer: state encoding, skid depth and the
// data/address defaults used together with the `fifo` block.
package lector_fifo_pkg;

  localparam int TAMANO_DATOS_DEF    = 10;
  localparam int TAMANO_DIRECION_DEF = 3;

  localparam int PROF_SKID  = 3;
  localparam int ANCHO_PTR  = $clog2(PROF_SKID);
  localparam int ANCHO_OCUP = $clog2(PROF_SKID + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ESPERA  = 2'd1;
  localparam logic [1:0] LECTURA = 2'd2;

  // Circular pointer advance over the skid entries.
  function automatic logic [ANCHO_PTR-1:0] sig_ptr(input logic [ANCHO_PTR-1:0] p);
    return (p == ANCHO_PTR'(PROF_SKID - 1)) ? '0 : p + ANCHO_PTR'(1);
  endfunction

endpackage

// File: rtl/buffer_salida_lector.sv
// In-order skid buffer between the FIFO read port and the downstream handshake.
// Head entry drives the outputs straight from registers.
module buffer_salida_lector
  import lector_fifo_pkg::*;
#(
  parameter int W = TAMANO_DATOS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [W-1:0]          din,
  input  logic                  pop,
  output logic                  valid,
  output logic [W-1:0]          dout,
  output logic [ANCHO_OCUP-1:0] ocupacion
);

  logic [PROF_SKID-1:0][W-1:0] mem;
  logic [ANCHO_PTR-1:0]        rd_ptr, wr_ptr;
  logic                        do_push, do_pop;

  assign do_pop  = pop && (ocupacion != '0);
  // A full buffer still accepts a word when the head leaves on the same edge.
  assign do_push = push && ((ocupacion != ANCHO_OCUP'(PROF_SKID)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      ocupacion <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= sig_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= sig_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   ocupacion <= ocupacion + ANCHO_OCUP'(1);
        2'b01:   ocupacion <= ocupacion - ANCHO_OCUP'(1);
        default: ocupacion <= ocupacion;
      endcase
    end
  end

  assign valid = (ocupacion != '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/lector_fifo.sv
// Consumer end of the `fifo` block: issues pops, captures read data into a
// skid buffer and re-presents it on a valid/ready handshake.
module lector_fifo
  import lector_fifo_pkg::*;
#(
  parameter int tamano_datos    = TAMANO_DATOS_DEF,
  parameter int tamano_direcion = TAMANO_DIRECION_DEF,
  parameter int TIMEOUT         = 16,
  parameter int ANCHO_CONT      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    modo_rafaga,
  input  logic                    fifo_empty,
  input  logic                    fifo_almost_empty,
  input  logic [tamano_datos-1:0] fifo_data_out,
  output logic                    fifo_read_enable,
  output logic                    valid_out,
  output logic [tamano_datos-1:0] data_out,
  input  logic                    ready_in,
  output logic [1:0]              estado,
  output logic [ANCHO_CONT-1:0]   palabras_leidas
);

  localparam int CW = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 1) begin : g_chk_timeout
    $error("lector_fifo: TIMEOUT must be at least 1");
  end
  if (tamano_direcion < 1) begin : g_chk_dir
    $error("lector_fifo: tamano_direcion must be at least 1");
  end

  logic                  en_vuelo;
  logic [CW-1:0]         cont;
  logic [1:0]            estado_sig;
  logic [ANCHO_OCUP-1:0] ocupacion;
  logic                  transfer;

  assign transfer = valid_out && ready_in;

  // Buffered plus in-flight words must fit the skid, so ready_in never reaches the pop.
  assign fifo_read_enable = (estado == LECTURA) && enable && !fifo_empty &&
                            ((ANCHO_OCUP'(ocupacion) + ANCHO_OCUP'(en_vuelo)) <
                             ANCHO_OCUP'(PROF_SKID));

  always_comb begin
    estado_sig = estado;
    if (!enable) begin
      estado_sig = IDLE;
    end else begin
      case (estado)
        IDLE:    estado_sig = modo_rafaga ? ESPERA : LECTURA;
        ESPERA:  if (!fifo_empty && (!fifo_almost_empty || cont == CW'(TIMEOUT - 1)))
                   estado_sig = LECTURA;
        LECTURA: if (modo_rafaga && fifo_empty) estado_sig = ESPERA;
        default: estado_sig = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado          <= IDLE;
      en_vuelo        <= 1'b0;
      cont            <= '0;
      palabras_leidas <= '0;
    end else begin
      estado   <= estado_sig;
      en_vuelo <= fifo_read_enable;
      if (estado == ESPERA && estado_sig == ESPERA && !fifo_empty)
        cont <= cont + CW'(1);
      else
        cont <= '0;
      if (transfer) palabras_leidas <= palabras_leidas + ANCHO_CONT'(1);
    end
  end

  buffer_salida_lector #(.W(tamano_datos)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (en_vuelo),
    .din       (fifo_data_out),
    .pop       (transfer),
    .valid     (valid_out),
    .dout      (data_out),
    .ocupacion (ocupacion)
  );

endmodule
